// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default sizing for the SPI sender.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} spi_state_t;
    localparam int SPI_DATA_W   = 16;
    localparam int SPI_HALF_DIV = 2;
    localparam int SPI_CS_GAP   = 2;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter producing rise/fall strikes while enabled.
module spi_clk_div #(
    parameter int HALF_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic en,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(HALF_DIV + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tick;
    always_comb begin
        tick    = en && (cnt_q == CW'(HALF_DIV - 1));
        cnt_d   = (!en || tick) ? '0 : cnt_q + 1'b1;
        phase_d = !en ? 1'b0 : phase_q ^ tick;
        o_rise  = tick && !phase_q;
        o_fall  = tick && phase_q;
    end
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/spi_sender.sv
// spi_sender: single-word mode-0 SPI transmit master.
// Define SPI_SENDER_LSB_FIRST_EN to send bit 0 first.
module spi_sender
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int HALF_DIV = SPI_HALF_DIV,
    parameter int CS_GAP   = SPI_CS_GAP
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_en,
    output logic              spi_clk,
    output logic              spi_csn,
    output logic              spi_sdi,
    output logic              o_busy,
    output logic              o_done
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(CS_GAP + 1);
`ifdef SPI_SENDER_LSB_FIRST_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = DATA_W - 1;
`endif
    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d, shifted;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              clk_q, clk_d, csn_q, csn_d, sdi_q, sdi_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rise, fall;

    spi_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .en       (state_q == SHIFT || state_q == HOLD),
        .o_rise   (rise),
        .o_fall   (fall)
    );

`ifdef SPI_SENDER_LSB_FIRST_EN
    assign shifted = {1'b0, sr_q[DATA_W-1:1]};
`else
    assign shifted = {sr_q[DATA_W-2:0], 1'b0};
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        clk_d   = clk_q;
        csn_d   = csn_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (i_data_en) begin
                state_d = SHIFT;
                sr_d    = i_data;
                bit_d   = '0;
                csn_d   = 1'b0;
                sdi_d   = i_data[FIRST];
                busy_d  = 1'b1;
            end
            SHIFT: if (rise) begin
                clk_d = 1'b1;
            end else if (fall) begin
                clk_d = 1'b0;
                if (bit_q == BW'(DATA_W - 1)) begin
                    state_d = HOLD;
                end else begin
                    sr_d  = shifted;
                    sdi_d = shifted[FIRST];
                    bit_d = bit_q + 1'b1;
                end
            end
            // the first strike after the last fall marks the end of the hold time
            HOLD: if (rise) begin
                state_d = GAP;
                csn_d   = 1'b1;
                sdi_d   = 1'b0;
                done_d  = 1'b1;
                gap_d   = '0;
            end
            GAP: if (gap_q == GW'(CS_GAP - 1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b0;
            csn_q   <= 1'b1;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            clk_q   <= clk_d;
            csn_q   <= csn_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign spi_clk = clk_q;
    assign spi_csn = csn_q;
    assign spi_sdi = sdi_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
endmodule

// File: tb/tb_spi_sender.sv
// tb_spi_sender: directed checks of spi_sender with default parameters.
module tb_spi_sender;
    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic [15:0] i_data = 16'hAA11;
    logic        i_data_en = 1'b1;
    logic        spi_clk, spi_csn, spi_sdi, o_busy, o_done;
    int          vecs = 0;
    int          errs = 0;
`ifdef SPI_SENDER_LSB_FIRST_EN
    localparam logic [15:0] EXP_BITS = 16'h8855;
    localparam logic        EXP_FIRST = 1'b1;
`else
    localparam logic [15:0] EXP_BITS = 16'hAA11;
    localparam logic        EXP_FIRST = 1'b1;
`endif

    spi_sender dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .i_data   (i_data),
        .i_data_en(i_data_en),
        .spi_clk  (spi_clk),
        .spi_csn  (spi_csn),
        .spi_sdi  (spi_sdi),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for chip select to fall, then records bits on spi_clk rises,
    // cycles low, o_done count and clk-high-while-deselected events.
    task automatic frame(output logic [15:0] bits, output int low, output int dn,
                         output int pre, output logic ok);
        logic prev;
        ok = 1'b0; bits = '0; low = 0; dn = 0; pre = 0; prev = 1'b0;
        while (spi_csn && pre < 200) begin
            pre++;
            @(negedge sys_clk);
        end
        if (spi_csn) return;
        while (!spi_csn && low < 500) begin
            if (spi_clk && !prev) bits = {bits[14:0], spi_sdi};
            prev = spi_clk;
            dn += int'(o_done);
            low++;
            @(negedge sys_clk);
        end
        dn += int'(o_done);
        @(negedge sys_clk);
        dn += int'(o_done);
        ok = 1'b1;
    endtask

    initial begin
        logic [15:0] bits;
        int          low, dn, pre, rises, lows, dones;
        logic        ok, prev;
        // reset held with a request pending
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            chk("reset_outputs", {spi_csn, spi_clk, spi_sdi, o_busy, o_done}, 5'b10000);
        end
        sys_reset = 1'b1;
        @(negedge sys_clk);
        i_data_en = 1'b0;
        chk("accept_csn", spi_csn, 0);
        chk("accept_sdi", spi_sdi, EXP_FIRST);
        chk("accept_busy", o_busy, 1);
        frame(bits, low, dn, pre, ok);
        chk("single_ok", ok, 1);
        chk("single_bits", bits, EXP_BITS);
        chk("single_low", low, 66);
        chk("single_done", dn, 1);
        @(negedge sys_clk);
        chk("gap_end_busy", o_busy, 0);
        chk("gap_end_sdi", spi_sdi, 0);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            lows += int'(!spi_csn) + int'(spi_clk);
        end
        chk("idle_quiet", lows, 0);
        // continuous requests
        i_data_en = 1'b1;
        frame(bits, low, dn, pre, ok);
        chk("cont1_bits", bits, EXP_BITS);
        chk("cont1_low", low, 66);
        for (int f = 0; f < 2; f++) begin
            frame(bits, low, dn, pre, ok);
            chk("cont_ok", ok, 1);
            chk("cont_gap", pre + 1, 3);
            chk("cont_bits", bits, EXP_BITS);
            chk("cont_low", low, 66);
            chk("cont_done", dn, 1);
        end
        i_data_en = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("cont_stop_csn", spi_csn, 1);
        // request while busy is ignored
        i_data_en = 1'b1;
        fork
            frame(bits, low, dn, pre, ok);
            begin
                @(negedge sys_clk);
                i_data_en = 1'b0;
                repeat (20) @(negedge sys_clk);
                i_data = 16'h1234;
                i_data_en = 1'b1;
                @(negedge sys_clk);
                i_data_en = 1'b0;
                i_data = 16'h0000;
            end
        join
        chk("busy_ok", ok, 1);
        chk("busy_bits", bits, EXP_BITS);
        chk("busy_low", low, 66);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            lows += int'(!spi_csn);
        end
        chk("busy_no_resend", lows, 0);
        // reset after the 5th rising edge
        i_data = 16'hAA11;
        i_data_en = 1'b1;
        @(negedge sys_clk);
        i_data_en = 1'b0;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 200 && rises < 5; i++) begin
            if (spi_clk && !prev) rises++;
            prev = spi_clk;
            if (rises < 5) @(negedge sys_clk);
        end
        chk("mid_rises", rises, 5);
        chk("mid_csn_low", spi_csn, 0);
        #1 sys_reset = 1'b0;
        #1;
        chk("mid_async", {spi_csn, spi_clk, spi_sdi, o_busy, o_done}, 5'b10000);
        repeat (3) @(negedge sys_clk);
        sys_reset = 1'b1;
        dones = 0; lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            dones += int'(o_done);
            lows += int'(!spi_csn);
        end
        chk("mid_no_done", dones, 0);
        chk("mid_no_resume", lows, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/spi_sender.md
Name: spi_sender

Overview:
- Single-word SPI transmit master.
- Accepts a parallel word on a valid strobe and serialises it MSB-first on a 3-wire write-only SPI bus (clock, active-low chip select, data out).
- Mode 0 (CPOL=0, CPHA=0); SPI clock derived from the system clock by an integer divider.
- Sits between register/DAC control logic and an external SPI slave (e.g. a DAC or config register).

Parameters:
- DATA_W, 16: bits per frame.
- HALF_DIV, 2: sys_clk cycles per SPI clock half-period; legal range ≥1. Default gives 12.5 MHz from 50 MHz.
- CS_GAP, 2: minimum sys_clk cycles chip select stays high between frames; legal range ≥1.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_reset  in  1  asynchronous, active-low reset.
- i_data  in  DATA_W  word to transmit.
- i_data_en  in  1  transmit request/valid, level-sensitive.
- spi_clk  out  1  SPI serial clock.
- spi_csn  out  1  SPI chip select, active low.
- spi_sdi  out  1  serial data to the slave's SDI.
- o_busy  out  1  high from acceptance until the gap completes.
- o_done  out  1  one-cycle pulse when spi_csn returns high.

Behaviour:
- Reset (sys_reset=0, asynchronous): spi_clk=0, spi_csn=1, spi_sdi=0, o_busy=0, o_done=0, state=IDLE. Shift register and counters are cleared.
- Reset mid-frame: outputs go to reset values immediately. The frame is abandoned and not resumed.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - If i_data_en=1 on a clock edge, latch i_data into the shift register and enter SHIFT.
  - In the next cycle: spi_csn=0, spi_sdi=i_data[DATA_W-1], o_busy=1.
- SHIFT:
  - Half-period counter counts HALF_DIV cycles per half.
  - spi_clk toggles at each half boundary, starting low.
  - Slave samples on rising edges, which occur HALF_DIV·(2k+1) cycles after spi_csn falls, for k=0..DATA_W-1.
  - On each falling edge except the last, the shift register shifts left and spi_sdi presents the next bit.
  - After the DATA_W-th falling edge (at 2·DATA_W·HALF_DIV cycles), enter HOLD with spi_clk=0.
- HOLD: spi_csn stays low for HALF_DIV cycles, then spi_csn=1. o_done pulses for exactly one cycle coincident with the spi_csn rise. Enter GAP.
- GAP: spi_csn=1 for CS_GAP cycles. spi_sdi=0. Then enter IDLE and drop o_busy.
- Frame length: spi_csn low for (2·DATA_W+1)·HALF_DIV cycles (66 with defaults).
- i_data_en:
  - Ignored while o_busy=1.
  - i_data may change freely after acceptance.
  - If i_data_en is held high, frames repeat back-to-back, separated by CS_GAP+1 cycles of spi_csn high.
- spi_clk is never high while spi_csn=1. No glitches on spi_clk.

Optional Feature:
- Macro SPI_SENDER_LSB_FIRST_EN.
- Defined: bit order reversed; i_data[0] is sent first and shifting is rightward. Timing is unchanged.
- Undefined (default): MSB-first as above.

Decomposition:
- Package spi_pkg holds:
  - state enum typedef spi_state_t (IDLE, SHIFT, HOLD, GAP);
  - default constants SPI_DATA_W=16, SPI_HALF_DIV=2, SPI_CS_GAP=2.
- One sub-module is natural: spi_clk_div, the half-period counter producing rise/fall strikes. The FSM and shift register stay in the top.

Test Plan:
- Reset: hold sys_reset=0 for 1000 ns, i_data_en=1 → spi_csn=1, spi_clk=0, spi_sdi=0, o_busy=0 throughout reset.
- Single frame: i_data=16'hAA11, i_data_en=1 after reset release. Required response:
  - bits sampled on 16 spi_clk rising edges = 1010_1010_0001_0001;
  - spi_csn low for 66 cycles;
  - o_done pulses once.
- Continuous request: i_data_en held 1 with constant 16'hAA11 → identical repeated frames with spi_csn high for exactly 3 cycles between them.
- Busy ignore: pulse i_data_en with 16'h1234 mid-frame of 16'hAA11 → current frame unchanged; 16'h1234 not sent.
- Reset mid-frame: assert sys_reset=0 after 5th rising edge → spi_csn=1, spi_clk=0 asynchronously (before next sys_clk edge); no o_done.
- LSB macro: compile with SPI_SENDER_LSB_FIRST_EN, send 16'hAA11 → sampled 1000_1000_0101_0101.
